// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined integer ALU with valid/hart-id sideband.
// Stage 1 computes arithmetic, compare, logic, byte-case conversion and the
// coarse (multiple-of-4) part of the shift; stage 2 finishes the shift,
// selects the result by op and registers it together with a zero flag.

package alu_pipe_pkg;

    localparam int ALUOP_WIDTH = 4;

    typedef logic [ALUOP_WIDTH-1:0] aluop_t;

    // Encoding 0 is deliberately left unused: the decoder's default output
    // must read as an unknown op and produce a zero result.
    localparam aluop_t ADD_OP     = 4'd1;
    localparam aluop_t SUB_OP     = 4'd2;
    localparam aluop_t SLL_OP     = 4'd3;
    localparam aluop_t SLT_OP     = 4'd4;
    localparam aluop_t SLTU_OP    = 4'd5;
    localparam aluop_t XOR_OP     = 4'd6;
    localparam aluop_t SRL_OP     = 4'd7;
    localparam aluop_t SRA_OP     = 4'd8;
    localparam aluop_t OR_OP      = 4'd9;
    localparam aluop_t AND_OP     = 4'd10;
    localparam aluop_t PASS_OP    = 4'd11;
    localparam aluop_t LOTOUPC_OP = 4'd12;

endpackage

module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int HART_W = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_valid,
    input  logic [ALUOP_WIDTH-1:0] i_ALUOp,
    input  logic [XLEN-1:0]        i_op_a,
    input  logic [XLEN-1:0]        i_op_b,
    input  logic [HART_W-1:0]      i_hart_id,
    input  logic                   i_flush,
    output logic                   o_valid,
    output logic [XLEN-1:0]        o_result,
    output logic [HART_W-1:0]      o_hart_id,
    output logic                   o_zero
);

    // Everything stage 1 hands to stage 2 except the valid bit, which is
    // kept apart because it is the only thing flush is allowed to touch.
    typedef struct packed {
        aluop_t            op;
        logic [HART_W-1:0] hart;
        logic [XLEN-1:0]   add_r;
        logic [XLEN-1:0]   sub_r;
        logic              lt_s;
        logic              lt_u;
        logic [XLEN-1:0]   xor_r;
        logic [XLEN-1:0]   or_r;
        logic [XLEN-1:0]   and_r;
        logic [XLEN-1:0]   shift_r;   // A shifted by shamt[4:2]*4
        logic [1:0]        fine_amt;  // remaining shamt[1:0] for stage 2
        logic [XLEN-1:0]   upc_r;
        logic [XLEN-1:0]   pass_r;
    } s1_t;

    s1_t               s1_d, s1_q;
    logic              valid1_d, valid1_q;

    logic              valid2_d, valid2_q;
    logic [HART_W-1:0] hart2_d, hart2_q;
    logic [XLEN-1:0]   result2_d, result2_q;
    logic              zero2_d, zero2_q;

    logic [4:0]        shamt;
    logic [4:0]        coarse_amt;
    logic [XLEN-1:0]   fine_shift;

    assign shamt      = i_op_b[4:0];
    assign coarse_amt = {shamt[4:2], 2'b00};

    // Stage 1 datapath: partial results and the coarse shift step.
    always_comb begin
        // NOTE: every field gets a value before any branch, so no path can leave one unassigned and infer a latch.
        s1_d          = '0;
        s1_d.op       = i_ALUOp;
        s1_d.hart     = i_hart_id;
        s1_d.add_r    = i_op_a + i_op_b;
        s1_d.sub_r    = i_op_a - i_op_b;
        s1_d.lt_s     = $signed(i_op_a) < $signed(i_op_b);
        s1_d.lt_u     = i_op_a < i_op_b;
        s1_d.xor_r    = i_op_a ^ i_op_b;
        s1_d.or_r     = i_op_a | i_op_b;
        s1_d.and_r    = i_op_a & i_op_b;
        s1_d.pass_r   = i_op_b;
        s1_d.fine_amt = shamt[1:0];

        // Direction and fill are chosen here so stage 2 keeps going the same way.
        case (i_ALUOp)
            SLL_OP:  s1_d.shift_r = i_op_a << coarse_amt;
            SRA_OP:  s1_d.shift_r = $signed(i_op_a) >>> coarse_amt;
            default: s1_d.shift_r = i_op_a >> coarse_amt;
        endcase

        // Lower-case ASCII letters lose bit 5; every other byte passes through.
        for (int i = 0; i < XLEN / 8; i++) begin
            if (i_op_a[8*i +: 8] >= 8'h61 && i_op_a[8*i +: 8] <= 8'h7A) begin
                s1_d.upc_r[8*i +: 8] = i_op_a[8*i +: 8] - 8'h20;
            end else begin
                s1_d.upc_r[8*i +: 8] = i_op_a[8*i +: 8];
            end
        end
    end

    // A flush kills the op being presented as well as the one already in stage 1.
    assign valid1_d = i_valid & ~i_flush;
    assign valid2_d = valid1_q & ~i_flush;

    // Stage 1 register: data every cycle, valid gated by flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the data registers are reset too, because o_result and o_hart_id must read zero out of reset.
            s1_q     <= '0;
            valid1_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values and the two stages cannot race.
            s1_q     <= s1_d;
            valid1_q <= valid1_d;
        end
    end

    // Stage 2 datapath: fine shift, result select and zero flag.
    always_comb begin
        case (s1_q.op)
            SLL_OP:  fine_shift = s1_q.shift_r << s1_q.fine_amt;
            SRA_OP:  fine_shift = $signed(s1_q.shift_r) >>> s1_q.fine_amt;
            default: fine_shift = s1_q.shift_r >> s1_q.fine_amt;
        endcase

        result2_d = '0;
        case (s1_q.op)
            ADD_OP:     result2_d = s1_q.add_r;
            SUB_OP:     result2_d = s1_q.sub_r;
            SLL_OP:     result2_d = fine_shift;
            SRL_OP:     result2_d = fine_shift;
            SRA_OP:     result2_d = fine_shift;
            SLT_OP:     result2_d = {{(XLEN-1){1'b0}}, s1_q.lt_s};
            SLTU_OP:    result2_d = {{(XLEN-1){1'b0}}, s1_q.lt_u};
            XOR_OP:     result2_d = s1_q.xor_r;
            OR_OP:      result2_d = s1_q.or_r;
            AND_OP:     result2_d = s1_q.and_r;
            PASS_OP:    result2_d = s1_q.pass_r;
            LOTOUPC_OP: result2_d = s1_q.upc_r;
            default:    result2_d = '0;
        endcase

        hart2_d = s1_q.hart;
        // The zero flag is qualified so a flushed or empty slot never reports zero.
        zero2_d = valid2_d & (result2_d == '0);
    end

    // Stage 2 register: the output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid2_q  <= 1'b0;
            hart2_q   <= '0;
            result2_q <= '0;
            zero2_q   <= 1'b0;
        end else begin
            valid2_q  <= valid2_d;
            hart2_q   <= hart2_d;
            result2_q <= result2_d;
            zero2_q   <= zero2_d;
        end
    end

    assign o_valid   = valid2_q;
    assign o_result  = result2_q;
    assign o_hart_id = hart2_q;
    assign o_zero    = zero2_q;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Two-stage pipelined integer ALU directly downstream of the ALU-op decoder. Consumes the registered `ALUOp` code together with the two operands and a hart tag, and produces a registered 32-bit result two cycles later. Splits the shifter across both stages and carries valid/hart-id sideband so the barrel-threaded execute stage can retire results in order without stalls.

## Interface
- `XLEN`, 32: operand/result width (only 32 supported).
- `HART_W`, 4: hart-id tag width.
- `ALUOP_WIDTH`, package value: width of `i_ALUOp`; encodings are the package constants `ADD_OP`, `SUB_OP`, `SLL_OP`, `SLT_OP`, `SLTU_OP`, `XOR_OP`, `SRL_OP`, `SRA_OP`, `OR_OP`, `AND_OP`, `PASS_OP`, `LOTOUPC_OP`.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_valid` in 1: operands/op valid this cycle.
- `i_ALUOp` in ALUOP_WIDTH: operation code, aligned with the operands.
- `i_op_a` in XLEN: operand A (rs1 / PC).
- `i_op_b` in XLEN: operand B (rs2 / immediate).
- `i_hart_id` in HART_W: tag of issuing hart.
- `i_flush` in 1: kill all in-flight operations.
- `o_valid` out 1: result valid.
- `o_result` out XLEN: ALU result.
- `o_hart_id` out HART_W: tag of result.
- `o_zero` out 1: `o_result == 0`, qualified with `o_valid`.

## Operation
- Stage 1 (S1 regs): capture op, hart id, valid, and partial results:
  - `add_r = a + b`, `sub_r = a - b` (32-bit wrap, carries discarded).
  - `lt_s` = signed a < b, `lt_u` = unsigned a < b.
  - Logic: `a^b`, `a|b`, `a&b`.
  - Coarse shift: shamt = `b[4:0]`; shift A by `shamt[4:2]*4` (left for SLL, logical right for SRL, arithmetic right for SRA); keep `shamt[1:0]` for S2.
  - LOTOUPC: per byte, if byte in 0x61..0x7A subtract 0x20, else unchanged.
  - PASS: B.
- Stage 2 (S2 regs): fine shift by `shamt[1:0]` (same direction/sign fill), result mux by op, SLT/SLTU zero-extend the 1-bit flag, compute `o_zero`.
- Unknown op codes (including all-zero default from decoder): result 0, `o_valid` still follows `i_valid`.
- Data registers update every cycle regardless of valid; only valid bits are gated.
- `i_flush`: clears S1 and S2 valid on the next edge; the operation presented with `i_flush` is also dropped. Flush does not clear data.
- No backpressure: one operation accepted per cycle, always.

## Timing
- Latency exactly 2 cycles: inputs sampled at edge N appear on outputs after edge N+1 and are stable until edge N+2.
- Throughput 1/cycle; back-to-back ops from different harts never interact.
- Reset (async assert, sync deassert expected upstream): `o_valid`=0, `o_result`=0, `o_hart_id`=0, `o_zero`=0 (zero flag gated by valid), internal valids 0. Reset mid-stream discards both in-flight ops.
- First valid output earliest 2 edges after `reset_n` release with `i_valid`=1.
- Simultaneous `i_flush` and `i_valid`: flush wins; nothing emerges for either pipeline slot.
- Shift by 0: result = A for all three shifts; SRA by 31 of 0x80000000 -> 0xFFFFFFFF.

## Test plan
- ADD/SUB wrap: a=0xFFFFFFFF, b=1, ADD_OP -> result 0, `o_zero`=1 two cycles later; SUB_OP a=0, b=1 -> 0xFFFFFFFF.
- Compare: a=0xFFFFFFFF, b=1: SLT_OP -> 1, SLTU_OP -> 0; a=b -> both 0.
- Shifts across split: a=0x80000001, shamt 0,1,3,4,7,31 for SLL/SRL/SRA -> golden model match (e.g. SRA 7 -> 0xFF000000, SLL 31 -> 0x80000000).
- LOTOUPC: a=0x617A407B ("az@{") -> 0x415A407B; PASS_OP b=0x12345678 -> 0x12345678; ALUOp=0 -> 0.
- Pipelining/tags: 16 consecutive valid ops, hart ids 0..15, random ops -> outputs in order, each 2 cycles later with matching hart id; insert `i_valid`=0 bubbles -> `o_valid` gaps at identical positions.
- Flush/reset: ops on cycles N, N+1, `i_flush` at N+1 -> neither emerges, op at N+2 emerges at N+4; assert `reset_n` low asynchronously mid-stream -> `o_valid`, `o_result`, `o_hart_id` go 0 immediately.
